mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the processor's single memory port between instruction fetch (IF, requester 0) and data memory access (DM, requester 1).
- Runs a round-robin request/grant FSM and drives `mem_sel`, the select of the 2:1 muxes that steer address and write data onto the port.
- Tracks memory wait states and aborts hung transactions with a timeout error.

Parameters:
- TIMEOUT, 16: maximum BUSY cycles without `mem_ready` before abort; legal range 2..255.
- CNT_WIDTH, 8: width of the wait counter; must hold TIMEOUT-1.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  IF request; held until `if_done`
- if_gnt  out  1  IF owns the port
- if_done  out  1  one-cycle IF completion pulse
- dm_req  in  1  DM request; held until `dm_done`
- dm_we  in  1  DM write (1) / read (0), sampled at grant
- dm_gnt  out  1  DM owns the port
- dm_done  out  1  one-cycle DM completion pulse
- mem_sel  out  1  port mux select: 0 = IF address, 1 = DM address/wdata
- mem_valid  out  1  transaction active on memory port
- mem_we  out  1  write strobe to memory
- mem_ready  in  1  memory accepts/completes the current transaction
- timeout_err  out  1  one-cycle pulse, coincident with done, on abort

Behaviour:
- Reset: clock and reset as decided — one clock, `clk`; reset `rst_n` is asynchronous, active-low.
  - On assertion: state=IDLE, `last_gnt`=DM (so IF wins the first tie), `wait_cnt`=0, `we_lat`=0.
  - All outputs 0 immediately, including `mem_sel`.
  - Reset mid-transaction abandons it; no done pulse is issued.
- States: IDLE, BUSY_IF, BUSY_DM.
- IDLE:
  - `mem_valid`=0, both `gnt`=0, `mem_we`=0; `mem_sel` holds its last value.
  - Only `if_req` set -> BUSY_IF next cycle.
  - Only `dm_req` set -> BUSY_DM next cycle.
  - Both set -> grant the requester that is not `last_gnt`.
  - On the transition: `mem_sel` registers 0/1, `last_gnt` updates, `wait_cnt` clears, `we_lat` registers `dm_we` (forced 0 for IF).
- BUSY_x:
  - `x_gnt`=1, `mem_valid`=1, `mem_we`=`we_lat` (DM only).
  - `mem_sel` is stable for the whole transaction.
- Completion (combinational in the ready cycle): `mem_ready`=1 in BUSY_x -> `x_done`=1 that cycle, next state IDLE.
- Timeout:
  - `mem_ready`=0 -> `wait_cnt`++.
  - If `wait_cnt`==TIMEOUT-1 and `mem_ready`=0: `x_done`=1 and `timeout_err`=1 that cycle, next state IDLE.
  - `mem_ready` in the same cycle as the timeout point wins: normal done, `timeout_err`=0.
- Latency:
  - `req` sampled in IDLE at cycle N -> `gnt`/`mem_valid` at N+1.
  - Zero-wait memory gives done at N+1.
  - At least one IDLE cycle always separates transactions, so back-to-back transactions from one requester occupy 2 cycles each.
- Request drop:
  - Deassertion during BUSY is ignored; the transaction runs to done or timeout.
  - A `req` still high in the IDLE cycle after its own done is a new request, arbitrated against the other requester's `last_gnt`.
- Ownership: `if_gnt` and `dm_gnt` are never high together; `done` is asserted only while the matching `gnt` is high.
- `dm_we` changes during BUSY_DM have no effect.

Test Plan:
- Reset mid-BUSY_DM with `mem_ready`=0 -> outputs 0 asynchronously; after release, `if_req`=`dm_req`=1 -> IF granted first, `mem_sel`=0.
- Both `req` held, `mem_ready` tied 1 -> grants alternate IF,DM,IF,DM; `done` every 2 cycles; `mem_sel` toggles 0,1,0,1.
- DM write, `dm_we`=1 at grant, then `dm_we`=0 during 3 wait cycles -> `mem_we`=1 for all 4 BUSY cycles; `dm_done` on the 4th.
- IF, `mem_ready` never asserted, TIMEOUT=16 -> `if_done`=`timeout_err`=1 in the 16th BUSY cycle, then IDLE.
- IF, `mem_ready` first rises in the 16th BUSY cycle -> `if_done`=1, `timeout_err`=0.
- `dm_req` dropped in the 2nd BUSY_DM cycle -> `dm_gnt` stays 1 until `mem_ready`; exactly one `dm_done`; no overlapping grants.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single memory port between instruction fetch (IF, requester 0)
// and data memory access (DM, requester 1). A round-robin request/grant FSM
// picks the owner, drives the address/wdata mux select and watches for hung
// transactions, aborting them with a timeout error.
//
// Parameters:
//   TIMEOUT    BUSY cycles without mem_ready before abort (2..255)
//   CNT_WIDTH  wait counter width; must hold TIMEOUT-1
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   if_req  / dm_req     requests, held by the requester until its done
//   dm_we                DM write(1)/read(0), sampled at grant
//   if_gnt  / dm_gnt     port ownership
//   if_done / dm_done    one-cycle completion pulses
//   mem_sel              port mux select: 0 = IF, 1 = DM
//   mem_valid, mem_we    transaction active / write strobe to memory
//   mem_ready            memory completes the current transaction
//   timeout_err          one-cycle pulse alongside done on abort
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT   = 16,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_req,
  output logic if_gnt,
  output logic if_done,
  input  logic dm_req,
  input  logic dm_we,
  output logic dm_gnt,
  output logic dm_done,
  output logic mem_sel,
  output logic mem_valid,
  output logic mem_we,
  input  logic mem_ready,
  output logic timeout_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] WAIT_LIMIT = CNT_WIDTH'(TIMEOUT - 1);

  state_t               state;
  state_t               state_nxt;
  logic                 last_gnt;   // 0 = IF served last, 1 = DM served last
  logic [CNT_WIDTH-1:0] wait_cnt;
  logic                 we_lat;
  logic                 sel_q;

  logic busy;
  logic at_limit;
  logic done;
  logic granting;

  assign busy     = (state != IDLE);
  assign at_limit = (wait_cnt == WAIT_LIMIT);
  // mem_ready in the timeout cycle still completes normally.
  assign done     = busy && (mem_ready || at_limit);
  assign granting = (state == IDLE) && (state_nxt != IDLE);

  // Next-state logic.
  // NOTE: every signal assigned here gets a default first, so no path
  // through the block can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        // On a tie the requester that was not served last wins.
        if (if_req && (!dm_req || last_gnt)) state_nxt = BUSY_IF;
        else if (dm_req)                     state_nxt = BUSY_DM;
      end
      BUSY_IF, BUSY_DM: begin
        // Request drops during BUSY are ignored; only done ends a transaction.
        if (done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register and per-transaction bookkeeping.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      wait_cnt <= '0;
      we_lat   <= 1'b0;
      sel_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (granting) begin
        last_gnt <= (state_nxt == BUSY_DM);
        sel_q    <= (state_nxt == BUSY_DM);
        wait_cnt <= '0;
        // Write intent is frozen at grant; later dm_we changes are ignored.
        we_lat   <= (state_nxt == BUSY_DM) && dm_we;
      end else if (busy && !mem_ready) begin
        wait_cnt <= wait_cnt + CNT_WIDTH'(1);
      end
    end
  end

  // Outputs decode directly from registered state, so reset clears them
  // immediately; mem_sel holds through IDLE.
  assign if_gnt      = (state == BUSY_IF);
  assign dm_gnt      = (state == BUSY_DM);
  assign mem_valid   = busy;
  assign mem_we      = (state == BUSY_DM) && we_lat;
  assign mem_sel     = sel_q;
  assign if_done     = (state == BUSY_IF) && done;
  assign dm_done     = (state == BUSY_DM) && done;
  assign timeout_err = busy && at_limit && !mem_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed stimulus for mem_port_arbiter. The stimulus thread pushes the
// expected completion (owner, timeout flag, cycle number) into a scoreboard
// queue; a monitor on the falling edge pops and compares whenever a done
// pulse appears. Cycle-level grant/select/strobe checks sit in the stimulus.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic if_req, dm_req, dm_we, mem_ready;
  logic if_gnt, if_done, dm_gnt, dm_done;
  logic mem_sel, mem_valid, mem_we, timeout_err;

  typedef struct {
    logic who;   // 0 = IF, 1 = DM
    logic to;    // expected timeout_err
    int   cyc;   // expected cycle of the done pulse
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  mem_port_arbiter #(.TIMEOUT(TIMEOUT), .CNT_WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_req     (if_req),
    .if_gnt     (if_gnt),
    .if_done    (if_done),
    .dm_req     (dm_req),
    .dm_we      (dm_we),
    .dm_gnt     (dm_gnt),
    .dm_done    (dm_done),
    .mem_sel    (mem_sel),
    .mem_valid  (mem_valid),
    .mem_we     (mem_we),
    .mem_ready  (mem_ready),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic who, input logic to, input int c);
    exp_t e;
    e.who = who;
    e.to  = to;
    e.cyc = c;
    sb.push_back(e);
  endtask

  // Monitor: ownership rules every active cycle, scoreboard on each done.
  always @(negedge clk) begin
    if (rst_n) begin
      if (if_gnt || dm_gnt) check("excl_gnt", {31'd0, if_gnt & dm_gnt}, 32'd0);
      if (timeout_err && !(if_done || dm_done)) check("err_without_done", 32'd1, 32'd0);
      if (if_done || dm_done) begin
        check("done_owner", {30'd0, if_done, dm_done}, {30'd0, if_gnt, dm_gnt});
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("done_who", {31'd0, dm_done}, {31'd0, e.who});
          check("done_timeout", {31'd0, timeout_err}, {31'd0, e.to});
          check("done_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    rst_n = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; mem_ready = 1'b0;
    tick(); tick();
    check("reset_outputs",
          {25'd0, if_gnt, if_done, dm_gnt, dm_done, mem_sel, mem_valid, mem_we, timeout_err}, 32'd0);
    rst_n = 1'b1;

    // ---- DM write granted, then reset mid-transaction ----
    dm_req = 1'b1; dm_we = 1'b1;
    tick();
    check("pre_rst_dm_gnt", {29'd0, dm_gnt, mem_sel, mem_we}, 32'd7);
    #1 rst_n = 1'b0;
    #1 check("async_rst_outputs",
             {27'd0, dm_gnt, dm_done, mem_sel, mem_valid, mem_we}, 32'd0);
    #1 rst_n = 1'b1;
    dm_we = 1'b0;

    // ---- both requests held, zero-wait memory: IF first, then alternate ----
    if_req = 1'b1; mem_ready = 1'b1;
    c0 = cyc;
    push(1'b0, 1'b0, c0 + 1);
    push(1'b1, 1'b0, c0 + 3);
    push(1'b0, 1'b0, c0 + 5);
    push(1'b1, 1'b0, c0 + 7);
    for (int k = 1; k <= 7; k++) begin
      tick();
      check($sformatf("rr_if_gnt_%0d", k), {31'd0, if_gnt}, {31'd0, (k == 1 || k == 5)});
      check($sformatf("rr_dm_gnt_%0d", k), {31'd0, dm_gnt}, {31'd0, (k == 3 || k == 7)});
      check($sformatf("rr_sel_%0d", k), {31'd0, mem_sel}, {31'd0, (k == 3 || k == 4 || k == 7)});
      check($sformatf("rr_we_%0d", k), {31'd0, mem_we}, 32'd0);
      if (k == 7) begin
        if_req = 1'b0;
        dm_req = 1'b0;
      end
    end
    tick();
    check("rr_idle", {30'd0, mem_valid, mem_sel}, 32'd1);
    mem_ready = 1'b0;

    // ---- DM write: dm_we drops during wait states, strobe must hold ----
    dm_req = 1'b1; dm_we = 1'b1;
    c0 = cyc;
    push(1'b1, 1'b0, c0 + 4);
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 1) dm_we = 1'b0;
      if (k == 4) begin
        mem_ready = 1'b1;
        dm_req = 1'b0;
      end
      #1 check($sformatf("wr_busy_%0d", k), {29'd0, dm_gnt, mem_sel, mem_we}, 32'd7);
    end
    tick();
    mem_ready = 1'b0;
    check("wr_idle", {30'd0, mem_valid, mem_we}, 32'd0);

    // ---- IF with memory never ready: timeout in 16th BUSY cycle ----
    if_req = 1'b1;
    c0 = cyc;
    push(1'b0, 1'b1, c0 + TIMEOUT);
    for (int k = 1; k <= TIMEOUT; k++) begin
      tick();
      if (k == TIMEOUT) if_req = 1'b0;
      if (k == TIMEOUT - 1) check("to_no_err_early", {30'd0, timeout_err, if_done}, 32'd0);
      if (k == TIMEOUT) check("to_err", {30'd0, timeout_err, if_done}, 32'd3);
    end
    tick();
    check("to_idle", {31'd0, mem_valid}, 32'd0);

    // ---- IF with ready arriving exactly at the timeout point ----
    if_req = 1'b1;
    c0 = cyc;
    push(1'b0, 1'b0, c0 + TIMEOUT);
    for (int k = 1; k <= TIMEOUT; k++) begin
      tick();
      if (k == TIMEOUT) begin
        mem_ready = 1'b1;
        if_req = 1'b0;
        #1 check("ready_wins", {30'd0, timeout_err, if_done}, 32'd1);
      end
    end
    tick();
    mem_ready = 1'b0;
    check("ready_idle", {31'd0, mem_valid}, 32'd0);

    // ---- DM request dropped in 2nd BUSY cycle: transaction still completes ----
    dm_req = 1'b1; dm_we = 1'b0;
    c0 = cyc;
    push(1'b1, 1'b0, c0 + 4);
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 2) dm_req = 1'b0;
      if (k == 4) mem_ready = 1'b1;
      #1 check($sformatf("drop_busy_%0d", k), {29'd0, if_gnt, dm_gnt, mem_we}, 32'd2);
    end
    tick();
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("drop_quiet_%0d", k), {30'd0, mem_valid, dm_gnt}, 32'd0);
      tick();
    end

    // ---- drain scoreboard ----
    for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
    check("sb_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
